camera_capture_sequencer: RTL and testbench



---
 rtl/camera_pkg.sv | 19 +
 rtl/cdc_sync_2ff.sv | 21 ++
 rtl/camera_capture_sequencer.sv | 145 ++++++++++++++
 tb/tb_camera_capture_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared capture states and status bit positions for the camera block
package camera_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        WAIT_END = 2'd2,
        DONE     = 2'd3
    } capture_state_t;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_TIMEOUT  = 2;
    localparam int ST_ABORT    = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_JPEG     = 5;
    localparam int ST_READ_END = 6;

endpackage

// File: rtl/cdc_sync_2ff.sv
// rtl/cdc_sync_2ff.sv - two-flop level synchroniser into the clk domain
module cdc_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/camera_capture_sequencer.sv
// rtl/camera_capture_sequencer.sv - frame-aligned capture sequencing, timeout, status and read address
module camera_capture_sequencer
    import camera_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 7_200_000,
    parameter logic [19:0] RGB_IMAGE_BYTES = 20'd768
) (
    input  logic        clock_spi_in,
    input  logic        reset_spi_in,
    input  logic        capture_request_in,
    input  logic        abort_request_in,
    input  logic        jpeg_select_in,
    input  logic        frame_valid_async_in,
    input  logic        jpeg_image_valid_in,
    input  logic [19:0] jpeg_image_size_in,
    input  logic        read_strobe_in,
    output logic        capture_in_progress_out,
    output logic        buffer_clear_out,
    output logic [15:0] read_address_out,
    output logic [19:0] image_size_out,
    output logic [7:0]  status_out
);

    localparam logic [23:0] TIMER_RELOAD = 24'(TIMEOUT_CYCLES - 1);

    capture_state_t state, next_state;
    logic        fv, fv_prev, fv_rise, fv_fall;
    logic        pending, busy, idle_like;
    logic        accept, set_pending, timeout_hit, overrun, reload;
    logic [23:0] timer;
    logic        done_flag, timeout_flag, abort_flag, overrun_flag, jpeg_mode;

    cdc_sync_2ff u_fv_sync (
        .clk (clock_spi_in),
        .rst (reset_spi_in),
        .d   (frame_valid_async_in),
        .q   (fv)
    );

    assign fv_rise   = fv & ~fv_prev;
    assign fv_fall   = ~fv & fv_prev;
    assign busy      = (state == ARMED) || (state == WAIT_END);
    assign idle_like = (state == IDLE) || (state == DONE);

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        set_pending = 1'b0;
        timeout_hit = 1'b0;
        overrun     = 1'b0;
        if (abort_request_in) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // a request seen mid-frame waits for the gap so capture starts on a whole frame
                    if ((capture_request_in || pending) && !fv) begin
                        accept     = 1'b1;
                        next_state = ARMED;
                    end else if (capture_request_in) begin
                        set_pending = 1'b1;
                    end
                end
                ARMED, WAIT_END: begin
                    overrun = capture_request_in;
                    if (timer == 24'd0) begin
                        timeout_hit = 1'b1;
                        next_state  = IDLE;
                    end else if (state == ARMED && fv_rise) begin
                        next_state = WAIT_END;
                    end else if (state == WAIT_END && fv_fall) begin
                        next_state = DONE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign reload = (next_state != state) && ((next_state == ARMED) || (next_state == WAIT_END));

    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in) begin
            state            <= IDLE;
            fv_prev          <= 1'b0;
            pending          <= 1'b0;
            timer            <= 24'd0;
            buffer_clear_out <= 1'b0;
            read_address_out <= 16'd0;
            image_size_out   <= 20'd0;
            done_flag        <= 1'b0;
            timeout_flag     <= 1'b0;
            abort_flag       <= 1'b0;
            overrun_flag     <= 1'b0;
            jpeg_mode        <= 1'b0;
        end else begin
            state            <= next_state;
            fv_prev          <= fv;
            buffer_clear_out <= accept;

            if (abort_request_in || accept) pending <= 1'b0;
            else if (set_pending)           pending <= 1'b1;

            if (reload)    timer <= TIMER_RELOAD;
            else if (busy) timer <= timer - 24'd1;

            if (accept) begin
                read_address_out <= 16'd0;
                image_size_out   <= 20'd0;
                jpeg_mode        <= jpeg_select_in;
                done_flag        <= 1'b0;
                timeout_flag     <= 1'b0;
                abort_flag       <= 1'b0;
                overrun_flag     <= 1'b0;
            end else if (read_strobe_in && idle_like && read_address_out != 16'hFFFF) begin
                read_address_out <= read_address_out + 16'd1;
            end

            if (abort_request_in) abort_flag   <= 1'b1;
            if (timeout_hit)      timeout_flag <= 1'b1;
            if (overrun)          overrun_flag <= 1'b1;

            if (next_state == DONE && state != DONE) begin
                done_flag <= 1'b1;
                if (!jpeg_mode)               image_size_out <= RGB_IMAGE_BYTES;
                else if (jpeg_image_valid_in) image_size_out <= jpeg_image_size_in;
                else                          image_size_out <= 20'd0;
            end
        end
    end

    assign capture_in_progress_out = busy;

    always_comb begin
        status_out              = 8'd0;
        status_out[ST_BUSY]     = busy;
        status_out[ST_DONE]     = done_flag;
        status_out[ST_TIMEOUT]  = timeout_flag;
        status_out[ST_ABORT]    = abort_flag;
        status_out[ST_OVERRUN]  = overrun_flag;
        status_out[ST_JPEG]     = jpeg_mode;
        status_out[ST_READ_END] = {4'd0, read_address_out} >= image_size_out;
    end

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// tb/tb_camera_capture_sequencer.sv - directed self-checking bench for camera_capture_sequencer
module tb_camera_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap = 1'b0, abort = 1'b0, jsel = 1'b0, fv = 1'b0;
    logic        jvalid = 1'b0, strobe = 1'b0;
    logic [19:0] jsize = 20'd0;
    logic        cip, clr;
    logic [15:0] addr;
    logic [19:0] size;
    logic [7:0]  status;

    logic        t_cap = 1'b0, t_zero = 1'b0;
    logic [19:0] t_zsize = 20'd0;
    logic        t_cip, t_clr;
    logic [15:0] t_addr;
    logic [19:0] t_size;
    logic [7:0]  t_status;

    int total = 0;
    int bad = 0;
    int clr_count = 0;

    always #5 clk = ~clk;

    camera_capture_sequencer #(.TIMEOUT_CYCLES(2000), .RGB_IMAGE_BYTES(20'd768)) dut (
        .clock_spi_in(clk), .reset_spi_in(rst),
        .capture_request_in(cap), .abort_request_in(abort), .jpeg_select_in(jsel),
        .frame_valid_async_in(fv), .jpeg_image_valid_in(jvalid), .jpeg_image_size_in(jsize),
        .read_strobe_in(strobe), .capture_in_progress_out(cip), .buffer_clear_out(clr),
        .read_address_out(addr), .image_size_out(size), .status_out(status)
    );

    camera_capture_sequencer #(.TIMEOUT_CYCLES(100), .RGB_IMAGE_BYTES(20'd768)) dut_to (
        .clock_spi_in(clk), .reset_spi_in(rst),
        .capture_request_in(t_cap), .abort_request_in(t_zero), .jpeg_select_in(t_zero),
        .frame_valid_async_in(t_zero), .jpeg_image_valid_in(t_zero), .jpeg_image_size_in(t_zsize),
        .read_strobe_in(t_zero), .capture_in_progress_out(t_cip), .buffer_clear_out(t_clr),
        .read_address_out(t_addr), .image_size_out(t_size), .status_out(t_status)
    );

    always @(negedge clk) if (clr) clr_count++;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(1);
        check("reset_cip", {31'd0, cip}, 32'd0);
        check("reset_clr", {31'd0, clr}, 32'd0);
        check("reset_addr", {16'd0, addr}, 32'd0);
        check("reset_size", {12'd0, size}, 32'd0);
        check("reset_status", {24'd0, status}, 32'h40);

        // abort and capture together in IDLE: abort wins
        cap = 1'b1; abort = 1'b1;
        step(1);
        cap = 1'b0; abort = 1'b0;
        check("abort_cap_cip", {31'd0, cip}, 32'd0);
        check("abort_cap_status", {24'd0, status}, 32'h48);
        step(1);
        check("abort_cap_noclr", clr_count, 32'd0);

        // RGB capture
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        check("rgb_clr", {31'd0, clr}, 32'd1);
        check("rgb_cip", {31'd0, cip}, 32'd1);
        check("rgb_status_busy", {24'd0, status}, 32'h41);
        fv = 1'b1;
        step(1000);
        check("rgb_cip_frame", {31'd0, cip}, 32'd1);
        fv = 1'b0;
        step(2);
        check("rgb_cip_before_done", {31'd0, cip}, 32'd1);
        step(1);
        check("rgb_cip_done", {31'd0, cip}, 32'd0);
        check("rgb_size", {12'd0, size}, 32'd768);
        check("rgb_status_done", {24'd0, status}, 32'h02);
        check("rgb_clr_once", clr_count, 32'd1);

        // request during a frame is held until the frame ends
        fv = 1'b1;
        step(3);
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        check("pend_cip_held", {31'd0, cip}, 32'd0);
        check("pend_status_held", {24'd0, status}, 32'h02);
        step(10);
        fv = 1'b0;
        step(2);
        check("pend_not_yet", {31'd0, cip}, 32'd0);
        step(1);
        check("pend_armed", {31'd0, cip}, 32'd1);
        fv = 1'b1;
        step(50);
        fv = 1'b0;
        step(3);
        check("pend_done_cip", {31'd0, cip}, 32'd0);
        check("pend_done_size", {12'd0, size}, 32'd768);
        check("pend_done_status", {24'd0, status}, 32'h02);
        check("pend_clr_count", clr_count, 32'd2);

        // JPEG capture
        jsel = 1'b1;
        cap = 1'b1;
        step(1);
        cap = 1'b0; jsel = 1'b0;
        check("jpeg_status_busy", {24'd0, status}, 32'h61);
        fv = 1'b1;
        step(20);
        fv = 1'b0; jvalid = 1'b1; jsize = 20'h01234;
        step(3);
        jvalid = 1'b0; jsize = 20'd0;
        check("jpeg_size", {12'd0, size}, 32'h01234);
        check("jpeg_status_done", {24'd0, status}, 32'h22);
        strobe = 1'b1;
        step(32'h1233);
        strobe = 1'b0;
        check("jpeg_addr_below", {16'd0, addr}, 32'h1233);
        check("jpeg_status_below", {24'd0, status}, 32'h22);
        strobe = 1'b1;
        step(1);
        strobe = 1'b0;
        check("jpeg_addr_end", {16'd0, addr}, 32'h1234);
        check("jpeg_status_end", {24'd0, status}, 32'h62);

        // read address saturation in DONE
        strobe = 1'b1;
        step(65540);
        strobe = 1'b0;
        check("sat_addr", {16'd0, addr}, 32'hFFFF);

        // strobes and overrun during WAIT_END, then abort
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        check("wait_status_busy", {24'd0, status}, 32'h41);
        check("wait_addr_cleared", {16'd0, addr}, 32'd0);
        fv = 1'b1;
        step(3);
        strobe = 1'b1;
        step(5);
        strobe = 1'b0;
        check("wait_strobe_ignored", {16'd0, addr}, 32'd0);
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        check("overrun_status", {24'd0, status}, 32'h51);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_cip", {31'd0, cip}, 32'd0);
        check("abort_status", {24'd0, status}, 32'h58);
        fv = 1'b0;
        step(3);

        // timeout with TIMEOUT_CYCLES = 100
        t_cap = 1'b1;
        step(1);
        t_cap = 1'b0;
        check("to_armed", {31'd0, t_cip}, 32'd1);
        step(99);
        check("to_still_armed", {31'd0, t_cip}, 32'd1);
        step(1);
        check("to_idle", {31'd0, t_cip}, 32'd0);
        check("to_status", {24'd0, t_status}, 32'h44);

        // asynchronous reset mid-capture
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        check("rst_pre_cip", {31'd0, cip}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_cip", {31'd0, cip}, 32'd0);
        check("rst_async_status", {24'd0, status}, 32'h40);
        step(1);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
